ecg_buffer_reader: RTL and testbench

- Read-side companion to the ping-pong sample-buffer writer (load_counter).
- The writer fills one BRAM bank with `load` 12-bit ECG samples, raises drc (data-ready), and flips `switch`.
- This block reads the completed bank through the BRAM port B and streams the samples downstream on a valid/ready interface.
- After the last sample it returns dc (data-consumed) to the writer so that bank can be reused.

---
 rtl/ecg_buf_pkg.sv | 27 ++
 rtl/ecg_rd_fifo.sv | 59 +++++
 rtl/ecg_buffer_reader.sv | 160 ++++++++++++++++
 tb/tb_ecg_buffer_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecg_buf_pkg.sv
// Shared constants, FSM state type and the read-credit helper for the ECG
// ping-pong buffer reader.
package ecg_buf_pkg;

  localparam int ECG_ADDR_W     = 12;
  localparam int ECG_DATA_W     = 12;
  localparam int ECG_BANK_SIZE  = 2048;
  localparam int ECG_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A new read may issue only if every sample already owed to the output
  // side (queued, returning from BRAM, minus the one leaving now) still fits.
  function automatic logic credit_ok(input logic [1:0] count,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] occ;
    occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    return (occ < 3'(ECG_FIFO_DEPTH));
  endfunction

endpackage

// File: rtl/ecg_rd_fifo.sv
// Two-entry synchronous FIFO holding {last, sample} between the BRAM read
// port and the downstream valid/ready interface.
module ecg_rd_fifo
  import ecg_buf_pkg::*;
#(
  parameter int W = ECG_DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic [1:0]   o_count,
  output logic         o_valid
);

  localparam logic [1:0] LP_FULL = 2'(ECG_FIFO_DEPTH);

  logic [W-1:0] r_mem [ECG_FIFO_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != LP_FULL) || w_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ECG_FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);

endmodule

// File: rtl/ecg_buffer_reader.sv
// Reads a completed ping-pong bank over BRAM port B and streams it out on a
// valid/ready interface, returning a one-cycle data-consumed pulse at the end.
module ecg_buffer_reader
  import ecg_buf_pkg::*;
#(
  parameter int ADDR_W    = ECG_ADDR_W,
  parameter int DATA_W    = ECG_DATA_W,
  parameter int BANK_SIZE = ECG_BANK_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_load,
  input  logic              i_drc,
  input  logic              i_switch,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic              o_m_last,
  output logic              o_dc,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] LP_BANK = ADDR_W'(BANK_SIZE);
  localparam logic [ADDR_W-1:0] LP_ONE  = ADDR_W'(1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_bank;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_sent;
  logic              r_busy;
  logic              r_armed;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_dc;

  logic [ADDR_W-1:0] w_load_len;
  logic              w_start;
  logic              w_issue;
  logic              w_pop;
  logic              w_fifo_valid;
  logic [1:0]        w_fifo_count;
  logic [DATA_W:0]   w_fifo_rdata;

  assign w_load_len = (i_load > LP_BANK) ? LP_BANK : i_load;
  assign w_start    = (r_state == ST_IDLE) && r_armed && i_drc && !r_busy;
  assign w_pop      = w_fifo_valid && i_m_ready;
  assign w_issue    = (r_state == ST_READ) && (r_idx < r_len) &&
                      credit_ok(w_fifo_count, r_inflight, w_pop);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_load_len == '0) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_READ;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_READ: begin
        if (r_idx == r_len) begin
          w_state_next = ST_DRAIN;
        end else begin
          w_state_next = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (r_sent == r_len) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Block context, counters and handshake flags; bank and length are frozen
  // at start so writer-side changes mid-block have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank          <= 1'b0;
      r_len           <= '0;
      r_idx           <= '0;
      r_sent          <= '0;
      r_busy          <= 1'b0;
      r_armed         <= 1'b1;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_dc            <= 1'b0;
    end else begin
      if (w_start) begin
        r_bank  <= ~i_switch;
        r_len   <= w_load_len;
        r_idx   <= '0;
        r_sent  <= '0;
        r_busy  <= 1'b1;
        r_armed <= 1'b0;
      end else begin
        if (w_issue) begin
          r_idx <= r_idx + LP_ONE;
        end
        if (w_pop) begin
          r_sent <= r_sent + LP_ONE;
        end
        if (!i_drc) begin
          r_armed <= 1'b1;
        end
        if (r_dc) begin
          r_busy <= 1'b0;
        end
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_idx == (r_len - LP_ONE));
      r_dc            <= (r_state == ST_DONE);
    end
  end

  ecg_rd_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_wdata ({r_inflight_last, i_rd_data}),
    .i_pop   (i_m_ready),
    .o_rdata (w_fifo_rdata),
    .o_count (w_fifo_count),
    .o_valid (w_fifo_valid)
  );

  assign o_rd_en   = w_issue;
  assign o_rd_addr = {r_bank, r_idx[ADDR_W-2:0]};
  assign o_m_data  = w_fifo_rdata[DATA_W-1:0];
  assign o_m_last  = w_fifo_rdata[DATA_W];
  assign o_m_valid = w_fifo_valid;
  assign o_dc      = r_dc;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_ecg_buffer_reader.sv
// Self-checking bench for ecg_buffer_reader: table-driven blocks, random
// blocks and hand-written reset/corner sequences against a bank-level model.
`timescale 1ns/1ps
module tb_ecg_buffer_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] i_load;
  logic        i_drc;
  logic        i_switch;
  logic [11:0] o_rd_addr;
  logic        o_rd_en;
  logic [11:0] i_rd_data;
  logic [11:0] o_m_data;
  logic        o_m_valid;
  logic        i_m_ready;
  logic        o_m_last;
  logic        o_dc;
  logic        o_busy;

  always #5 clk = ~clk;

  ecg_buffer_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (i_load),
    .i_drc     (i_drc),
    .i_switch  (i_switch),
    .o_rd_addr (o_rd_addr),
    .o_rd_en   (o_rd_en),
    .i_rd_data (i_rd_data),
    .o_m_data  (o_m_data),
    .o_m_valid (o_m_valid),
    .i_m_ready (i_m_ready),
    .o_m_last  (o_m_last),
    .o_dc      (o_dc),
    .o_busy    (o_busy)
  );

  logic [11:0] bram [4096];
  int n_checks = 0;
  int n_pass   = 0;
  int rmode    = 0;
  int rphase   = 0;

  // Monitor state
  int cyc = 0;
  int mon_reads, mon_beats, mon_dc, mon_max_out, mon_hold_err;
  int drc_cyc, first_rd_cyc, first_valid_cyc, first_beat_cyc, last_beat_cyc, dc_cyc;
  int mon_addr[$];
  int mon_data[$];
  int mon_last[$];
  logic        prev_stall;
  logic [12:0] prev_out;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  task automatic mon_clear();
    mon_reads = 0; mon_beats = 0; mon_dc = 0; mon_max_out = 0; mon_hold_err = 0;
    drc_cyc = -1; first_rd_cyc = -1; first_valid_cyc = -1;
    first_beat_cyc = -1; last_beat_cyc = -1; dc_cyc = -1;
    mon_addr.delete(); mon_data.delete(); mon_last.delete();
    prev_stall = 1'b0; prev_out = '0;
  endtask

  // BRAM port-B model: registered read, data one cycle after rd_en.
  initial begin
    i_rd_data = '0;
    forever begin
      @(posedge clk);
      if (o_rd_en) i_rd_data <= bram[o_rd_addr];
    end
  end

  // Downstream ready pattern: 0 always, 1 = 1,0,0,1 repeating, 2 random.
  initial begin
    i_m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rphase++;
      case (rmode)
        1:       i_m_ready = ((rphase % 4) == 0) || ((rphase % 4) == 3);
        2:       i_m_ready = 1'($urandom_range(0, 1));
        default: i_m_ready = 1'b1;
      endcase
    end
  end

  // Observation on the falling edge, away from the active edge.
  initial begin
    mon_clear();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n === 1'b1) begin
        if (i_drc && drc_cyc < 0) drc_cyc = cyc;
        if (o_rd_en) begin
          mon_addr.push_back(int'(o_rd_addr));
          mon_reads++;
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (o_m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stall && (!o_m_valid || ({o_m_last, o_m_data} != prev_out))) mon_hold_err++;
        prev_stall = o_m_valid && !i_m_ready;
        prev_out   = {o_m_last, o_m_data};
        if (o_m_valid && i_m_ready) begin
          mon_data.push_back(int'(o_m_data));
          mon_last.push_back(int'(o_m_last));
          mon_beats++;
          if (first_beat_cyc < 0) first_beat_cyc = cyc;
          last_beat_cyc = cyc;
        end
        if (o_dc) begin
          mon_dc++;
          dc_cyc = cyc;
        end
        if (mon_reads - mon_beats > mon_max_out) mon_max_out = mon_reads - mon_beats;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // One block: start it, wait for dc, hold drc high (no re-read), compare to model.
  task automatic run_block(input int load, input bit sw, input int rm, input bit mutate,
                           input bit chk_addr, input int exp_first, input int exp_last);
    int n, errs, budget, bank, a;
    bit got, mutated;
    n    = (load > 2048) ? 2048 : load;
    bank = sw ? 0 : 1;
    mon_clear();
    rmode    = rm;
    i_load   = 12'(load);
    i_switch = sw;
    @(posedge clk); #1;
    i_drc = 1'b1;
    budget  = 4 * n + 60;
    got     = 1'b0;
    mutated = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (mutate && !mutated && mon_beats >= 3) begin
        i_load   = 12'd3;
        i_switch = ~sw;
        mutated  = 1'b1;
      end
      if (mon_dc > 0) begin
        got = 1'b1;
        break;
      end
    end
    check("dc_seen", int'(got), 1);
    if (got) begin
      check("busy_at_dc", int'(o_busy), 1);
      @(negedge clk); #1;
      check("busy_after_dc", int'(o_busy), 0);
      check("dc_one_cycle", int'(o_dc), 0);
    end
    repeat (8) @(negedge clk);
    #1;
    check("beats", mon_beats, n);
    check("reads", mon_reads, n);
    check("dc_pulses", mon_dc, 1);
    check("max_outstanding_le2", int'(mon_max_out <= 2), 1);
    check("hold_while_stalled_errs", mon_hold_err, 0);
    errs = 0;
    for (int i = 0; i < n; i++) begin
      a = bank * 2048 + i;
      if (i >= mon_data.size() || mon_data[i] != int'(bram[a]) ||
          mon_last[i] != ((i == n - 1) ? 1 : 0)) errs++;
      if (i >= mon_addr.size() || mon_addr[i] != a) errs++;
    end
    check("sequence_errs", errs, 0);
    if (n > 0) begin
      check("rd_en_latency", first_rd_cyc - drc_cyc, 1);
      check("m_valid_latency", first_valid_cyc - drc_cyc, 3);
      if (rm == 0) check("throughput", last_beat_cyc - first_beat_cyc, n - 1);
    end else begin
      check("dc_latency_len0", dc_cyc - drc_cyc, 2);
    end
    if (chk_addr && mon_addr.size() > 0) begin
      check("first_addr", mon_addr[0], exp_first);
      check("last_addr", mon_addr[mon_addr.size() - 1], exp_last);
    end
    @(posedge clk); #1;
    i_drc = 1'b0;
  endtask

  typedef struct {
    int load;
    bit sw;
    int rm;
    bit mutate;
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    tbl[0] = '{load: 10,   sw: 1'b0, rm: 0, mutate: 1'b0, exp_first: 'h800, exp_last: 'h809};
    tbl[1] = '{load: 10,   sw: 1'b0, rm: 1, mutate: 1'b0, exp_first: 'h800, exp_last: 'h809};
    tbl[2] = '{load: 0,    sw: 1'b0, rm: 0, mutate: 1'b0, exp_first: 0,     exp_last: 0};
    tbl[3] = '{load: 4000, sw: 1'b0, rm: 0, mutate: 1'b0, exp_first: 'h800, exp_last: 'hFFF};
    tbl[4] = '{load: 1,    sw: 1'b1, rm: 0, mutate: 1'b0, exp_first: 'h000, exp_last: 'h000};
    tbl[5] = '{load: 10,   sw: 1'b1, rm: 2, mutate: 1'b0, exp_first: 'h000, exp_last: 'h009};
    tbl[6] = '{load: 10,   sw: 1'b0, rm: 2, mutate: 1'b1, exp_first: 'h800, exp_last: 'h809};
    tbl[7] = '{load: 2049, sw: 1'b1, rm: 1, mutate: 1'b0, exp_first: 'h000, exp_last: 'h7FF};

    for (int a = 0; a < 4096; a++) bram[a] = 12'($urandom);
    for (int i = 0; i < 10; i++) begin
      logic [11:0] v;
      v = 12'h100 + 12'(i);
      bram[12'h800 + 12'(i)] = v;
    end

    rst_n = 1'b0; i_drc = 1'b0; i_switch = 1'b0; i_load = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", int'(o_rd_en), 0);
    check("rst_m_valid", int'(o_m_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_dc", int'(o_dc), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      run_block(tbl[v].load, tbl[v].sw, tbl[v].rm, tbl[v].mutate, 1'b1,
                tbl[v].exp_first, tbl[v].exp_last);
    end

    // Reset in the middle of a block: outputs clear immediately, no dc.
    mon_clear();
    rmode = 0; i_load = 12'd10; i_switch = 1'b0;
    @(posedge clk); #1;
    i_drc = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (mon_beats >= 5) begin
        done = 1'b1;
        break;
      end
    end
    check("midreset_reached_5_beats", int'(done), 1);
    rst_n = 1'b0;
    #1;
    check("async_rd_en", int'(o_rd_en), 0);
    check("async_rd_addr", int'(o_rd_addr), 0);
    check("async_m_valid", int'(o_m_valid), 0);
    check("async_m_data", int'(o_m_data), 0);
    check("async_m_last", int'(o_m_last), 0);
    check("async_dc", int'(o_dc), 0);
    check("async_busy", int'(o_busy), 0);
    repeat (3) @(posedge clk);
    #1;
    i_drc = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("no_dc_after_abort", mon_dc, 0);
    run_block(10, 1'b0, 0, 1'b0, 1'b1, 'h800, 'h809);

    for (int r = 0; r < 8; r++) begin
      run_block(int'($urandom_range(0, 90)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), 1'b0, 1'b0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
